// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared definitions for the byte-lane data memory: access size encodings,
//   the controller state type and the alignment rule used by the memory and
//   by anything else that issues requests on its behalf.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // True when an access of the given size cannot be served at this lane.
    // Size 3 has no defined meaning and is always treated as a fault.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic r;
        case (size)
            SZ_B:    r = 1'b0;
            SZ_H:    r = lane[0];
            SZ_W:    r = (lane != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align
//   Combinational load formatter: picks the addressed byte/half out of a
//   32-bit word, moves it to bit 0 and sign- or zero-extends it.
//   Ports:
//     word_i      32-bit word as stored
//     lane_i      byte offset inside the word
//     size_i      SZ_B / SZ_H / SZ_W
//     unsigned_i  1 = zero-extend, 0 = sign-extend (ignored for words)
//     data_o      formatted load data
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = word_i >> {lane_i, 3'b000};

    always_comb begin
        data_o = word_i;
        case (size_i)
            SZ_B:    data_o = unsigned_i ? {24'd0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    data_o = unsigned_i ? {16'd0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane
//   Byte-addressed data memory for the MEM stage. Byte/half/word stores via
//   lane enables, extended loads, misalignment faulting, optional registered
//   load path, and a clear sequencer that zeroes the (unreset) array.
//   Ports:
//     clk, reset        clock, async active-high reset
//     req_valid/ready   request handshake; ready only once the array is usable
//     req_we            1 = store
//     req_size          0 byte, 1 half, 2 word, 3 illegal
//     req_unsigned      zero-extend loads
//     req_addr          byte address (wraps modulo 4*DEPTH)
//     req_wdata         store data, low-aligned
//     rd_valid/rd_data  load response
//     misalign_err      fault flag, timed with the response
//     init_busy         clear sequence running
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 32,
    parameter int READ_LAT   = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic              misalign_err,
    output logic              init_busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             ready_q, busy_q;

    logic [31:0] mem [0:DEPTH-1];

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             mis, accept, wr_en, ld_fire, err_fire;
    logic [3:0]       be;
    logic [31:0]      wdata_rep, rd_word, aligned, load_data;
    logic             unused_addr;

    assign idx         = req_addr[IDX_W+1:2];
    assign lane        = req_addr[1:0];
    assign unused_addr = ^req_addr[ADDR_W-1:IDX_W+2];

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    // ready/busy are registered from the next state so that their reset
    // values hold regardless of which state reset selects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= (INIT_CLEAR != 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_RUN);
            busy_q  <= (state_d == ST_INIT);
        end
    end

    assign req_ready = ready_q;
    assign init_busy = busy_q;

    // ------------------------------------------------------ request decode
    assign mis      = misaligned(req_size, lane);
    assign accept   = req_valid & ready_q;
    assign wr_en    = accept & req_we & ~mis;
    assign ld_fire  = accept & ~req_we;
    assign err_fire = accept & mis;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = req_wdata;
        case (req_size)
            SZ_B: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // --------------------------------------------------------------- array
    // Clear writes and request writes are mutually exclusive: requests are
    // only accepted once ready_q is set, which coincides with leaving INIT.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    // Read sees the array before this edge's write, so a load is unaffected
    // by a store accepted in the same or any later cycle.
    assign rd_word = mem[idx];

    dmem_load_align u_align (
        .word_i     (rd_word),
        .lane_i     (lane),
        .size_i     (req_size),
        .unsigned_i (req_unsigned),
        .data_o     (aligned)
    );

    assign load_data = mis ? 32'd0 : aligned;

    // ------------------------------------------------------------ response
    generate
        if (READ_LAT == 0) begin : g_comb
            assign rd_valid     = ld_fire;
            assign misalign_err = err_fire;
            // Forced to zero when idle so reset/idle value is defined.
            assign rd_data      = ld_fire ? load_data : 32'd0;
        end else begin : g_reg
            logic        rv_q, err_q;
            logic [31:0] data_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rv_q   <= 1'b0;
                    err_q  <= 1'b0;
                    data_q <= '0;
                end else begin
                    rv_q  <= ld_fire;
                    err_q <= err_fire;
                    if (ld_fire) data_q <= load_data;
                end
            end
            assign rd_valid     = rv_q;
            assign misalign_err = err_q;
            assign rd_data      = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_bytelane.sv
module tb_dmem_bytelane;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        rdy0, rv0, me0, busy0;
    logic        rdy1, rv1, me1, busy1;
    logic [31:0] rd0, rd1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic        vld;
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dmem_bytelane #(.DEPTH(256), .ADDR_W(32), .READ_LAT(0), .INIT_CLEAR(1)) u_lat0 (
        .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(rdy0),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rd_valid(rv0),
        .rd_data(rd0), .misalign_err(me0), .init_busy(busy0)
    );

    dmem_bytelane #(.DEPTH(256), .ADDR_W(32), .READ_LAT(1), .INIT_CLEAR(1)) u_lat1 (
        .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(rdy1),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rd_valid(rv1),
        .rd_data(rd1), .misalign_err(me1), .init_busy(busy1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ monitors
    always @(negedge clk) begin
        if (!rst && (rv0 || me0)) begin
            if (q0.size() == 0) begin
                chk("lat0_unexpected_response", {rv0, me0}, 2'b00);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("lat0_valid", rv0, e.vld);
                chk("lat0_err", me0, e.err);
                chk("lat0_latency", cyc, e.cyc);
                if (e.vld) chk("lat0_data", rd0, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (rv1 || me1)) begin
            if (q1.size() == 0) begin
                chk("lat1_unexpected_response", {rv1, me1}, 2'b00);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("lat1_valid", rv1, e.vld);
                chk("lat1_err", me1, e.err);
                chk("lat1_latency", cyc, e.cyc + 1);
                if (e.vld) chk("lat1_data", rd1, e.data);
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    // Called at posedge+1; drives one request for exactly one cycle.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        if (!we || exp_err) begin
            e.vld  = ~we;
            e.err  = exp_err;
            e.data = exp_err ? 32'd0 : exp_data;
            e.cyc  = cyc;
            q0.push_back(e);
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        req_we    = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts init_busy cycles from reset release until RUN, checking that the
    // memory never signals ready meanwhile. Keeps a store pending throughout
    // to prove requests in INIT are dropped.
    task automatic release_and_count(input string tag);
        int  n;
        logic bad_ready;
        n = 0;
        bad_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SZ_W;
        req_addr  = 32'h0;
        req_wdata = 32'hDEADBEEF;
        rst = 1'b0;
        @(negedge clk);
        while (busy0 && n < 1000) begin
            n++;
            if (rdy0 || rdy1 || !busy1) bad_ready = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        chk({tag, "_busy_cycles"}, n, 256);
        chk({tag, "_ready_low_in_init"}, bad_ready, 1'b0);
        chk({tag, "_run_ready"}, {rdy0, rdy1, busy0, busy1}, 4'b1100);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_lat0", {rdy0, rv0, me0, busy0, rd0}, {4'b0001, 32'd0});
        chk("reset_lat1", {rdy1, rv1, me1, busy1, rd1}, {4'b0001, 32'd0});
        @(posedge clk);
        #1;

        // 1: clear sequence, cleared memory, dropped INIT store
        release_and_count("init1");
        issue(0, SZ_W, 0, 32'h3FC, 0, 32'h0, 0);
        issue(0, SZ_W, 0, 32'h000, 0, 32'h0, 0);

        // 2: word then byte store, loads
        issue(1, SZ_W, 0, 32'h10, 32'h11223344, 0, 0);
        issue(1, SZ_B, 0, 32'h11, 32'h000000AA, 0, 0);
        issue(0, SZ_W, 0, 32'h10, 0, 32'h1122AA44, 0);
        issue(0, SZ_B, 0, 32'h11, 0, 32'hFFFFFFAA, 0);
        issue(0, SZ_B, 1, 32'h11, 0, 32'h000000AA, 0);

        // 3: half stores on both halves, signed/unsigned
        issue(1, SZ_W, 0, 32'h20, 32'h12345678, 0, 0);
        issue(1, SZ_H, 0, 32'h22, 32'hFFFF8001, 0, 0);
        issue(0, SZ_H, 0, 32'h22, 0, 32'hFFFF8001, 0);
        issue(0, SZ_H, 1, 32'h22, 0, 32'h00008001, 0);
        issue(0, SZ_W, 0, 32'h20, 0, 32'h80015678, 0);
        issue(1, SZ_W, 0, 32'h24, 32'hFFFFFFFF, 0, 0);
        issue(1, SZ_H, 0, 32'h24, 32'h00007FFE, 0, 0);
        issue(0, SZ_W, 0, 32'h24, 0, 32'hFFFF7FFE, 0);
        issue(0, SZ_H, 0, 32'h24, 0, 32'h00007FFE, 0);
        issue(0, SZ_B, 0, 32'h27, 0, 32'hFFFFFFFF, 0);
        issue(0, SZ_B, 1, 32'h27, 0, 32'h000000FF, 0);

        // 4: misaligned accesses fault and leave memory alone
        issue(0, SZ_W, 0, 32'h13, 0, 0, 1);
        issue(1, SZ_H, 0, 32'h21, 32'h0000BEEF, 0, 1);
        issue(0, 2'd3, 0, 32'h00, 0, 0, 1);
        issue(1, 2'd3, 0, 32'h10, 32'h0, 0, 1);
        issue(0, SZ_H, 1, 32'h23, 0, 0, 1);
        issue(0, SZ_W, 0, 32'h20, 0, 32'h80015678, 0);
        issue(0, SZ_W, 0, 32'h10, 0, 32'h1122AA44, 0);

        // 5: address wrap
        issue(1, SZ_W, 0, 32'h404, 32'hCAFEF00D, 0, 0);
        issue(0, SZ_W, 0, 32'h004, 0, 32'hCAFEF00D, 0);
        issue(0, SZ_W, 0, 32'hFFFF0004, 0, 32'hCAFEF00D, 0);

        // load then store to same word, back to back
        issue(0, SZ_W, 0, 32'h10, 0, 32'h1122AA44, 0);
        issue(1, SZ_W, 0, 32'h10, 32'h55667788, 0, 0);
        issue(0, SZ_W, 0, 32'h10, 0, 32'h55667788, 0);
        issue(0, SZ_B, 0, 32'h13, 0, 32'h00000055, 0);
        idle(4);
        chk("queues_drained_1", q0.size() + q1.size(), 0);

        // 6: reset mid-clear restarts the full sequence
        rst = 1'b1;
        idle(2);
        release_and_count("init2");
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(100);
        rst = 1'b1;
        idle(2);
        @(negedge clk);
        chk("midinit_reset_state", {rdy0, busy0, rdy1, busy1}, 4'b0101);
        @(posedge clk);
        #1;
        release_and_count("init3");
        issue(0, SZ_W, 0, 32'h10, 0, 32'h0, 0);
        issue(0, SZ_W, 0, 32'h004, 0, 32'h0, 0);
        idle(4);
        chk("queues_drained_2", q0.size() + q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
